// File: rtl/note_seq_pkg.sv
// Shared definitions for the note sequencer: state encoding, end-of-song
// marker, tempo decode and default field widths.
package note_seq_pkg;

  localparam int DEF_BEAT_W    = 22;
  localparam int DEF_BEAT_LOAD = 3125000;
  localparam int DEF_NOTE_W    = 6;
  localparam int DEF_DUR_W     = 6;
  localparam int DEF_IDX_W     = 5;

  // A ROM entry whose duration field equals this value terminates the song.
  localparam int END_MARK = 0;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_FETCH = 3'd1;
  localparam state_t S_LOAD  = 3'd2;
  localparam state_t S_PLAY  = 3'd3;
  localparam state_t S_DONE  = 3'd4;

  // Right-shift applied to the beat reload value; selection 3 falls back to x1.
  function automatic logic [1:0] tempo_shift(input logic [1:0] sel);
    return (sel == 2'd3) ? 2'd0 : sel;
  endfunction

endpackage

// File: rtl/note_seq_beat_gen.sv
// Beat countdown: counts down while enabled, ticks at zero and reloads
// from the tempo-scaled load value on that same cycle.
module beat_gen
  import note_seq_pkg::*;
#(
  parameter int                BEAT_W    = DEF_BEAT_W,
  parameter logic [BEAT_W-1:0] BEAT_LOAD = BEAT_W'(DEF_BEAT_LOAD)
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              clear_i,
  input  logic              load_i,
  input  logic [BEAT_W-1:0] load_val_i,
  output logic              beat_o,
  output logic              tick_o
);

  logic [BEAT_W-1:0] count_q;
  logic              beat_q;

  assign tick_o = en_i && !clear_i && (count_q == '0);
  assign beat_o = beat_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= BEAT_LOAD;
      beat_q  <= 1'b0;
    end else if (clear_i) begin
      count_q <= BEAT_LOAD;
      beat_q  <= 1'b0;
    end else if (load_i) begin
      count_q <= load_val_i;
      beat_q  <= 1'b0;
    end else if (tick_o) begin
      count_q <= load_val_i;
      beat_q  <= 1'b1;
    end else if (en_i) begin
      count_q <= count_q - 1'b1;
      beat_q  <= 1'b0;
    end else begin
      beat_q  <= 1'b0;
    end
  end

endmodule

// File: rtl/note_sequencer.sv
// Steps through a song ROM of {note, dur} entries, timing each note in beats
// and emitting note_start pulses plus a sticky end-of-song flag.
module note_sequencer
  import note_seq_pkg::*;
#(
  parameter int                BEAT_W    = DEF_BEAT_W,
  parameter logic [BEAT_W-1:0] BEAT_LOAD = BEAT_W'(DEF_BEAT_LOAD),
  parameter int                NOTE_W    = DEF_NOTE_W,
  parameter int                DUR_W     = DEF_DUR_W,
  parameter int                IDX_W     = DEF_IDX_W
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    play_i,
  input  logic                    reset_song_i,
  input  logic [1:0]              song_sel_i,
  input  logic [1:0]              tempo_sel_i,
  output logic [IDX_W+1:0]        rom_addr_o,
  input  logic [NOTE_W+DUR_W-1:0] rom_data_i,
  output logic [NOTE_W-1:0]       note_o,
  output logic                    note_start_o,
  output logic                    note_active_o,
  output logic                    beat_o,
  output logic                    song_done_o
);

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d, idx_next;
  logic [DUR_W-1:0]   remain_q, remain_d;
  logic [NOTE_W-1:0]  note_q, note_d;
  logic               note_start_q, note_start_d;
  logic               note_active_q, note_active_d;
  logic               song_done_q, song_done_d;
  logic [IDX_W+1:0]   rom_addr_q, rom_addr_d;
  logic [1:0]         song_sel_q;

  logic [NOTE_W-1:0]  rom_note;
  logic [DUR_W-1:0]   rom_dur;
  logic               restart;
  logic               play_en;
  logic               load_note;
  logic               tick;
  logic [BEAT_W-1:0]  load_val;

  assign rom_note  = rom_data_i[NOTE_W+DUR_W-1:DUR_W];
  assign rom_dur   = rom_data_i[DUR_W-1:0];
  assign restart   = reset_song_i || (song_sel_i != song_sel_q);
  assign play_en   = (state_q == S_PLAY) && play_i;
  assign load_note = (state_q == S_LOAD) && (rom_dur != DUR_W'(END_MARK));
  assign load_val  = BEAT_LOAD >> tempo_shift(tempo_sel_i);
  assign idx_next  = idx_q + 1'b1;

  beat_gen #(
    .BEAT_W    (BEAT_W),
    .BEAT_LOAD (BEAT_LOAD)
  ) u_beat_gen (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .en_i       (play_en),
    .clear_i    (restart),
    .load_i     (load_note),
    .load_val_i (load_val),
    .beat_o     (beat_o),
    .tick_o     (tick)
  );

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    remain_d     = remain_q;
    note_d       = note_q;
    note_start_d = 1'b0;
    song_done_d  = song_done_q;
    rom_addr_d   = rom_addr_q;

    case (state_q)
      S_IDLE: begin
        if (play_i) begin
          state_d    = S_FETCH;
          rom_addr_d = {song_sel_q, idx_q};
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        if (rom_dur == DUR_W'(END_MARK)) begin
          state_d     = S_DONE;
          song_done_d = 1'b1;
        end else begin
          state_d      = S_PLAY;
          note_d       = rom_note;
          remain_d     = rom_dur;
          note_start_d = 1'b1;
        end
      end
      S_PLAY: begin
        if (tick) begin
          remain_d = remain_q - 1'b1;
          // Last beat of the note: the final index ends the song rather than wrapping.
          if (remain_q == DUR_W'(1)) begin
            if (idx_q == {IDX_W{1'b1}}) begin
              state_d     = S_DONE;
              song_done_d = 1'b1;
            end else begin
              state_d    = S_FETCH;
              idx_d      = idx_next;
              rom_addr_d = {song_sel_q, idx_next};
            end
          end
        end
      end
      S_DONE:  song_done_d = 1'b1;
      default: state_d = S_IDLE;
    endcase

    if (restart) begin
      state_d      = S_IDLE;
      idx_d        = '0;
      rom_addr_d   = {song_sel_i, {IDX_W{1'b0}}};
      song_done_d  = 1'b0;
      note_start_d = 1'b0;
    end

    note_active_d = (state_d == S_PLAY) && play_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      idx_q         <= '0;
      remain_q      <= '0;
      note_q        <= '0;
      note_start_q  <= 1'b0;
      note_active_q <= 1'b0;
      song_done_q   <= 1'b0;
      rom_addr_q    <= '0;
      song_sel_q    <= '0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      remain_q      <= remain_d;
      note_q        <= note_d;
      note_start_q  <= note_start_d;
      note_active_q <= note_active_d;
      song_done_q   <= song_done_d;
      rom_addr_q    <= rom_addr_d;
      song_sel_q    <= song_sel_i;
    end
  end

  assign rom_addr_o    = rom_addr_q;
  assign note_o        = note_q;
  assign note_start_o  = note_start_q;
  assign note_active_o = note_active_q;
  assign song_done_o   = song_done_q;

endmodule

// File: tb/tb_note_sequencer.sv
// Scoreboard bench for note_sequencer with a 4-cycle beat: expected notes,
// lengths and gaps are queued up front and checked as notes start and end.
module tb_note_sequencer;

  logic        clk;
  logic        rstN;
  logic        play;
  logic        resetSong;
  logic [1:0]  songSel;
  logic [1:0]  tempoSel;
  logic [6:0]  romAddr;
  logic [11:0] romData;
  logic [5:0]  noteOut;
  logic        noteStart;
  logic        noteActive;
  logic        beat;
  logic        songDone;

  logic [11:0] rom [0:127];

  typedef struct {
    logic [5:0] note;
    int         len;
    int         gap;
  } noteExp_t;

  noteExp_t sbQ[$];
  noteExp_t cur;

  int checks = 0;
  int failures = 0;
  int startCount = 0;
  int beatCount = 0;
  int curLen = 0;
  int gapCnt = 0;
  bit inNote = 0;
  bit prevDone = 0;

  note_sequencer #(
    .BEAT_LOAD (22'd3)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rstN),
    .play_i        (play),
    .reset_song_i  (resetSong),
    .song_sel_i    (songSel),
    .tempo_sel_i   (tempoSel),
    .rom_addr_o    (romAddr),
    .rom_data_i    (romData),
    .note_o        (noteOut),
    .note_start_o  (noteStart),
    .note_active_o (noteActive),
    .beat_o        (beat),
    .song_done_o   (songDone)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Synchronous song ROM: data follows the registered address by one cycle.
  always @(posedge clk) romData <= rom[romAddr];

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic finalizeNote();
    if (cur.len >= 0) checkOutput("noteLen", curLen, cur.len);
    inNote = 0;
  endtask

  task automatic flushNote();
    inNote = 0;
    gapCnt = 0;
  endtask

  // One clock of monitoring, sampled on the falling edge.
  task automatic applyStimulus();
    @(negedge clk);
    if (noteStart) begin
      if (inNote) finalizeNote();
      startCount++;
      if (sbQ.size() == 0) begin
        checkOutput("sbUnderflow", sbQ.size(), 1);
        cur.len = -1;
      end else begin
        cur = sbQ.pop_front();
        checkOutput("noteVal", noteOut, cur.note);
        if (cur.gap >= 0) checkOutput("noteGap", gapCnt, cur.gap);
      end
      inNote = 1;
      curLen = 0;
    end
    if (noteActive) begin
      curLen++;
      gapCnt = 0;
    end else begin
      gapCnt++;
    end
    if (beat) beatCount++;
    if (songDone && !prevDone && inNote) finalizeNote();
    prevDone = songDone;
  endtask

  task automatic runUntilDone(input int budget);
    for (int i = 0; i < budget && !songDone; i++) applyStimulus();
    checkOutput("songDone", songDone, 1);
  endtask

  task automatic runUntilStarts(input int n, input int budget);
    for (int i = 0; i < budget && startCount < n; i++) applyStimulus();
    checkOutput("startWait", startCount, n);
  endtask

  task automatic newScenario();
    startCount = 0;
    beatCount = 0;
    flushNote();
  endtask

  initial begin
    for (int i = 0; i < 128; i++) rom[i] = '0;
    rom[0] = {6'd5, 6'd2};
    rom[1] = {6'd9, 6'd1};
    for (int i = 0; i < 32; i++) rom[32 + i] = {6'(i + 1), 6'd1};
    rom[64] = {6'd7, 6'd3};
    rom[96] = {6'd11, 6'd4};

    rstN = 1'b0; play = 1'b0; resetSong = 1'b0; songSel = 2'd0; tempoSel = 2'd0;
    #12;
    checkOutput("rstAddr", romAddr, 0);
    checkOutput("rstNote", noteOut, 0);
    checkOutput("rstStart", noteStart, 0);
    checkOutput("rstActive", noteActive, 0);
    checkOutput("rstBeat", beat, 0);
    checkOutput("rstDone", songDone, 0);
    rstN = 1'b1;
    applyStimulus();

    // Basic playback of song 0.
    newScenario();
    sbQ.push_back('{6'd5, 8, -1});
    sbQ.push_back('{6'd9, 4, 2});
    play = 1'b1;
    runUntilDone(200);
    checkOutput("beats1", beatCount, 3);
    checkOutput("sbEmpty1", sbQ.size(), 0);
    checkOutput("doneInactive", noteActive, 0);

    // Pause mid-note.
    play = 1'b0;
    resetSong = 1'b1;
    applyStimulus();
    resetSong = 1'b0;
    checkOutput("rsDoneClr", songDone, 0);
    checkOutput("rsAddr", romAddr, 0);
    newScenario();
    sbQ.push_back('{6'd5, 8, -1});
    sbQ.push_back('{6'd9, 4, 2});
    play = 1'b1;
    for (int i = 0; i < 6; i++) applyStimulus();
    play = 1'b0;
    begin
      int pauseViol = 0;
      for (int i = 0; i < 10; i++) begin
        applyStimulus();
        if (noteActive || beat) pauseViol++;
      end
      checkOutput("pauseQuiet", pauseViol, 0);
    end
    play = 1'b1;
    runUntilDone(200);
    checkOutput("beats2", beatCount, 3);
    checkOutput("sbEmpty2", sbQ.size(), 0);

    // Double tempo on song 2.
    play = 1'b0;
    songSel = 2'd2;
    tempoSel = 2'd1;
    applyStimulus();
    applyStimulus();
    newScenario();
    sbQ.push_back('{6'd7, 6, -1});
    play = 1'b1;
    runUntilDone(200);
    checkOutput("beats3", beatCount, 3);
    checkOutput("sbEmpty3", sbQ.size(), 0);
    tempoSel = 2'd0;

    // reset_song during the second note of song 0.
    play = 1'b0;
    songSel = 2'd0;
    applyStimulus();
    applyStimulus();
    newScenario();
    sbQ.push_back('{6'd5, 8, -1});
    sbQ.push_back('{6'd9, -1, 2});
    play = 1'b1;
    runUntilStarts(2, 100);
    resetSong = 1'b1;
    applyStimulus();
    resetSong = 1'b0;
    checkOutput("midRsAddr", romAddr, 0);
    checkOutput("midRsActive", noteActive, 0);
    flushNote();
    sbQ.push_back('{6'd5, 8, -1});
    sbQ.push_back('{6'd9, 4, 2});
    runUntilDone(200);
    checkOutput("sbEmpty4", sbQ.size(), 0);

    // Full 32-entry song: ends after index 31 without wrapping.
    play = 1'b0;
    songSel = 2'd1;
    applyStimulus();
    applyStimulus();
    newScenario();
    for (int i = 0; i < 32; i++) sbQ.push_back('{6'(i + 1), 4, (i == 0) ? -1 : 2});
    play = 1'b1;
    runUntilDone(1000);
    checkOutput("fullStarts", startCount, 32);
    checkOutput("fullAddr", romAddr, 63);
    checkOutput("sbEmpty5", sbQ.size(), 0);
    for (int i = 0; i < 20; i++) applyStimulus();
    checkOutput("noWrapStarts", startCount, 32);
    checkOutput("noWrapActive", noteActive, 0);
    checkOutput("doneSticky", songDone, 1);
    play = 1'b0;
    songSel = 2'd3;
    applyStimulus();
    checkOutput("selDoneClr", songDone, 0);
    checkOutput("selAddr", romAddr, 96);

    // Asynchronous reset in the middle of a note.
    newScenario();
    sbQ.push_back('{6'd11, -1, -1});
    play = 1'b1;
    runUntilStarts(1, 50);
    for (int i = 0; i < 3; i++) applyStimulus();
    #2 rstN = 1'b0;
    #1;
    checkOutput("arstAddr", romAddr, 0);
    checkOutput("arstNote", noteOut, 0);
    checkOutput("arstStart", noteStart, 0);
    checkOutput("arstActive", noteActive, 0);
    checkOutput("arstBeat", beat, 0);
    checkOutput("arstDone", songDone, 0);
    play = 1'b0;
    sbQ.delete();
    applyStimulus();
    rstN = 1'b1;
    newScenario();
    for (int i = 0; i < 5; i++) applyStimulus();
    checkOutput("idleStarts", startCount, 0);
    checkOutput("idleActive", noteActive, 0);
    sbQ.push_back('{6'd11, -1, -1});
    play = 1'b1;
    runUntilStarts(1, 20);
    checkOutput("resumeActive", noteActive, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/note_sequencer.md
# note_sequencer

Plays a stored song by stepping through ROM entries of {note, duration-in-beats} and timing each note against an internal beat tick. It sits between the song ROM and the note player in the music-player datapath. It owns the beat countdown: it configures the reload value from a tempo selection and starts, pauses and restarts the countdown. It issues one `note_start` pulse per note and flags the end of the song.

## Interface
- `BEAT_LOAD`, default 22'd3125000: beat countdown reload value. Nominal beat period is BEAT_LOAD+1 cycles.
- `BEAT_W`, default 22: beat counter width.
- `NOTE_W`, default 6: note code width.
- `DUR_W`, default 6: duration field width, in beats.
- `IDX_W`, default 5: note index width (32 entries per song).
- `clk  in  1`: sole clock; all logic on the rising edge.
- `rst  in  1`: asynchronous, active-low reset.
- `play  in  1`: level input. 1 = run, 0 = pause.
- `reset_song  in  1`: synchronous pulse; restart the current song at index 0.
- `song_sel  in  2`: song select. A change acts as `reset_song`.
- `tempo_sel  in  2`: 0 = ×1, 1 = ×2, 2 = ×4 speed, 3 = ×1.
- `rom_addr  out  2+IDX_W`: {song_sel, idx}, registered.
- `rom_data  in  NOTE_W+DUR_W`: {note, dur}. Synchronous ROM, valid the cycle after `rom_addr` changes.
- `note  out  NOTE_W`: current note, held until the next note loads.
- `note_start  out  1`: one-cycle pulse marking the first cycle of a note.
- `note_active  out  1`: high in PLAY while `play`=1.
- `beat  out  1`: one-cycle beat tick pulse.
- `song_done  out  1`: sticky end-of-song flag.

## Operation
- States: IDLE, FETCH, LOAD, PLAY, DONE.
- Reset values: state=IDLE, idx=0, `rom_addr`=0, `note`=0, `note_start`=0, `note_active`=0, `beat`=0, `song_done`=0. Beat counter = BEAT_LOAD.
- IDLE: when `play`=1, go to FETCH.
- FETCH: wait one cycle for the ROM, then go to LOAD.
- LOAD: capture rom_data.
  - dur==0 is the end marker: go to DONE and issue no `note_start`.
  - Otherwise: `note`←note field, remaining←dur, beat counter ← current load value, `note_start`←1, go to PLAY.
- PLAY with `play`=1:
  - The beat counter decrements each cycle.
  - At count 0: `beat`=1 and the counter reloads with load value = BEAT_LOAD >> (tempo_sel==3 ? 0 : tempo_sel). `tempo_sel` is sampled only at reload.
  - Each `beat` decrements remaining.
  - When a beat arrives with remaining==1: if idx==2^IDX_W−1, go to DONE; else idx←idx+1 and go to FETCH.
- PLAY with `play`=0: counter, remaining and idx are frozen. `beat`=0 and `note_active`=0. `note` is held.
- DONE: `song_done`=1, `note_active`=0. Held until `reset_song` or a `song_sel` change.
- `reset_song`, or `song_sel` differing from its registered copy, takes effect from any state and overrides all other transitions:
  - go to IDLE; idx←0; counter←BEAT_LOAD;
  - `song_done`←0, `note_start`←0, `note_active`←0.
- `play` deasserting in FETCH or LOAD does not stall the fetch. The pause takes effect in PLAY.

## Timing
- `play` sampled high in IDLE at edge k: FETCH after k, LOAD after k+1. `note_start`=1 and `note_active`=1 in the cycle after edge k+2.
- Note length at tempo ×1: dur×(BEAT_LOAD+1) cycles of `note_active`, excluding paused cycles.
- Inter-note gap: exactly 2 cycles (FETCH, LOAD) with `note_active`=0.
- `rom_addr` is updated on the edge that enters FETCH.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Structure
- Package `note_seq_pkg` holds:
  - the state enum;
  - the END_MARK constant (dur==0);
  - the tempo-shift decode;
  - default widths.
- Sub-module `beat_gen` contains:
  - the BEAT_W down-counter with load value input, `en` and `clear`;
  - `beat` output = (count==0)&&en, with reload on that cycle.
- Sequencer FSM, idx/remaining registers and `song_sel` change detect live in `note_sequencer`.

## Test plan
All scenarios use BEAT_LOAD=3 (4-cycle beat).
- ROM [{5,2},{9,1},{x,0}], `play`=1 held: `note_start` pulses with note=5 and then 9. `note_active` is high for 8 cycles, then 4 cycles, with 2-cycle gaps. `song_done`=1 after the end marker.
- `play` dropped for 10 cycles mid-note: `note_active` and `beat` low for those cycles. The note resumes and completes its remaining beats; total active cycles are unchanged.
- `tempo_sel`=1 set before a note loads: the beat period becomes 2 cycles (load=1); a dur=3 note is active for 6 cycles.
- `reset_song` pulsed during PLAY at idx=1: next cycle is IDLE with `rom_addr`={song,0}. Playback restarts with note 5.
- Song of 32 nonzero-duration entries: after idx 31 completes, go to DONE with no wrap to idx 0. A `song_sel` change clears `song_done`.
- `rst` asserted mid-note: all outputs go to 0 asynchronously. After release, stay in IDLE until `play`.
